// File: rtl/filt_seq_ctrl.sv
// Filter-chain sequencer: turns ADC sample strobes into staggered HPF/LPF
// enables, flushes and re-settles the filters on start or input clipping,
// and decimates the LPF output into a validated sample stream.
module filt_seq_ctrl #(
  parameter int Width    = 10,
  parameter int SETTLE   = 32,
  parameter int DECIM    = 4,
  parameter int CLIP_RUN = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    smp_strobe,
  input  logic signed [Width-1:0] x_in,
  input  logic signed [Width-1:0] y_lpf,
  output logic                    hpf_en,
  output logic                    lpf_en,
  output logic                    stage_rst,
  output logic signed [Width-1:0] y_out,
  output logic                    y_valid,
  output logic                    settled,
  output logic                    busy,
  output logic                    clip_err,
  output logic                    overrun
);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_SETTLE, S_RUN} state_t;

  localparam int STAGES = 3;
  localparam logic signed [Width-1:0] XMAX = {1'b0, {(Width-1){1'b1}}};
  localparam logic signed [Width-1:0] XMIN = {1'b1, {(Width-1){1'b0}}};

  state_t              state_q, state_d;
  // [0] accepted, [1] hpf_en, [2] lpf_en, [3] y_valid
  logic [STAGES:0]     vld_pipe;
  // marks the in-flight sample that closes a decimation window
  logic [STAGES-1:0]   emit_pipe;
  logic                flush_cnt;
  logic [7:0]          settle_cnt, clip_cnt, clip_inc, clip_nx;
  logic [3:0]          dec_cnt;
  logic                active, strobe_ok, pipe_busy, accept_raw, accept, drop;
  logic                is_fs, clip_hit, settle_go, flush_entry, kill, emit, dec_wrap;

  // Next-state and per-cycle control decode
  always_comb begin
    state_d     = state_q;
    active      = (state_q == S_SETTLE) || (state_q == S_RUN);
    strobe_ok   = smp_strobe && active && !start && !stop;
    // one sample in flight: busy until its lpf_en cycle begins
    pipe_busy   = vld_pipe[0] || vld_pipe[1];
    accept_raw  = strobe_ok && !pipe_busy;
    drop        = strobe_ok && pipe_busy;
    is_fs       = (x_in == XMAX) || (x_in == XMIN);
    clip_inc    = (clip_cnt == 8'hFF) ? 8'hFF : clip_cnt + 8'd1;
    clip_nx     = is_fs ? clip_inc : 8'd0;
    clip_hit    = accept_raw && is_fs && (clip_inc >= 8'(CLIP_RUN));
    accept      = accept_raw && !clip_hit;
    dec_wrap    = (dec_cnt == 4'(DECIM - 1));
    emit        = (state_q == S_RUN) && dec_wrap;
    settle_go   = (state_q == S_SETTLE) && vld_pipe[2] && (settle_cnt >= 8'(SETTLE));
    flush_entry = start || clip_hit;
    kill        = start || stop || clip_hit;
    if (start) begin
      state_d = S_FLUSH;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_FLUSH: if (flush_cnt) state_d = S_SETTLE;
        default: begin
          if (stop)           state_d = S_IDLE;
          else if (clip_hit)  state_d = S_FLUSH;
          else if (settle_go) state_d = S_RUN;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Counters, enable pipeline, output sample and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt  <= 1'b0;
      settle_cnt <= '0;
      dec_cnt    <= '0;
      clip_cnt   <= '0;
      vld_pipe   <= '0;
      emit_pipe  <= '0;
      y_out      <= '0;
      clip_err   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      flush_cnt <= (state_d == S_FLUSH) && !flush_entry;
      if (flush_entry) begin
        settle_cnt <= '0;
        dec_cnt    <= '0;
        clip_cnt   <= '0;
      end else if (accept_raw) begin
        clip_cnt <= clip_nx;
        if (state_q == S_SETTLE && settle_cnt != 8'hFF) settle_cnt <= settle_cnt + 8'd1;
        if (state_q == S_RUN) dec_cnt <= dec_wrap ? 4'd0 : dec_cnt + 4'd1;
      end
      vld_pipe[0] <= accept;
      vld_pipe[1] <= vld_pipe[0] && !kill;
      vld_pipe[2] <= vld_pipe[1] && !kill;
      vld_pipe[3] <= vld_pipe[2] && emit_pipe[2] && !kill;
      emit_pipe   <= {emit_pipe[1:0], accept && emit};
      if (vld_pipe[2] && emit_pipe[2] && !kill) y_out <= y_lpf;
      if (start)         clip_err <= 1'b0;
      else if (clip_hit) clip_err <= 1'b1;
      if (start)         overrun <= 1'b0;
      else if (drop)     overrun <= 1'b1;
    end
  end

  assign hpf_en    = vld_pipe[1];
  assign lpf_en    = vld_pipe[2];
  assign y_valid   = vld_pipe[3];
  assign stage_rst = (state_q == S_FLUSH);
  assign settled   = (state_q == S_RUN);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/filt_seq_ctrl.md
Name: filt_seq_ctrl

Overview:
- Sequencer for the pre-processing filter chain (HPF -> LPF) in the BPM datapath.
- Converts the ADC sample strobe into staggered single-cycle enables for each filter stage.
- Flushes and re-settles the filters on start or input clipping, and decimates the LPF output into a validated sample stream for the BPM counter.
- Sits between the sampling front end and the pre-processing filters; the filters' en pins are driven only by this block.

Parameters:
- Width, 10, sample width (signed) of x_in, y_lpf and y_out
- SETTLE, 32, accepted samples discarded after flush before output is valid (1..255)
- DECIM, 4, output decimation ratio; one y_valid per DECIM accepted samples (1..15)
- CLIP_RUN, 8, consecutive full-scale input samples that trigger re-settle (1..255)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: begin or restart the filter run
- stop  in  1  pulse: end the run and return to IDLE
- smp_strobe  in  1  one-cycle pulse, new ADC sample on x_in
- x_in  in  Width  signed ADC sample, valid with smp_strobe
- y_lpf  in  Width  signed LPF output
- hpf_en  out  1  HPF enable pulse
- lpf_en  out  1  LPF enable pulse
- stage_rst  out  1  filter-stage synchronous reset, active-high
- y_out  out  Width  registered decimated output sample
- y_valid  out  1  one-cycle pulse, y_out updated
- settled  out  1  high in RUN state
- busy  out  1  high in any state other than IDLE
- clip_err  out  1  sticky clip flag, cleared by start or rst
- overrun  out  1  sticky flag, strobe dropped, cleared by start or rst

Behaviour:
Reset (rst=1 at a clk edge):
- State goes to IDLE.
- All outputs are 0, y_out=0.
- All counters and the pipeline are cleared.
- rst takes priority over every other input, including mid-pipeline and mid-flush.

States: IDLE, FLUSH, SETTLE, RUN.
- IDLE:
  - Strobes are ignored; hpf_en and lpf_en stay 0.
  - start -> FLUSH.
- FLUSH:
  - stage_rst=1 for exactly 2 cycles, then SETTLE.
  - Strobes during FLUSH are ignored (not counted as overrun).
  - Settle, decimation and clip counters are cleared on entry.
- SETTLE:
  - Each accepted sample increments settle_cnt.
  - When settle_cnt reaches SETTLE, the state moves to RUN on the cycle after that sample's lpf_en.
  - No y_valid is produced in SETTLE.
- RUN:
  - settled=1.
  - Each accepted sample increments dec_cnt, which wraps at DECIM.
  - On wrap, y_out is captured and y_valid pulses.
- stop in SETTLE or RUN -> IDLE next cycle; any in-flight enable pulses are cancelled.
- start in FLUSH, SETTLE or RUN -> FLUSH; clip_err and overrun are cleared.
- start and stop in the same cycle: start wins.

Per-sample pipeline (strobe accepted at edge T):
- hpf_en=1 during cycle T+1.
- lpf_en=1 during cycle T+2.
- y_lpf is sampled at edge T+3; y_out and y_valid are registered then, so y_valid is high in cycle T+3.
- Fixed latency is 3 cycles from strobe to y_valid.
- Only one sample may be in flight. A strobe at T+1 or T+2 is dropped and sets overrun.
- A strobe at T+3 or later is accepted.

Clip detection (SETTLE and RUN):
- An accepted sample with x_in equal to the most positive value (2^(Width-1)-1) or most negative value (-2^(Width-1)) increments clip_cnt; any other value clears it.
- When clip_cnt reaches CLIP_RUN: clip_err is set, the state goes to FLUSH, and that sample is not propagated (no hpf_en).

Counter widths:
- settle_cnt: 8 bits.
- dec_cnt: 4 bits.
- clip_cnt: 8 bits, saturating.

Outputs:
- All outputs are registered; no combinational input-to-output paths.

Test Plan:
- Reset, then start, then 40 strobes every 4 cycles with x_in=10 -> stage_rst high 2 cycles; hpf_en/lpf_en pulse at T+1/T+2 for each strobe; no y_valid for the first 32 samples; settled rises after sample 32; y_valid on samples 36 and 40 with y_out=y_lpf sampled at T+3.
- RUN with DECIM=4, 16 strobes and y_lpf driven to the sample index -> exactly 4 y_valid pulses, y_out = 4, 8, 12, 16.
- Strobes at T and T+2 -> second strobe dropped, overrun=1, no extra hpf_en; a strobe at T+3 is accepted normally.
- In RUN, 8 consecutive samples x_in=511 -> clip_err=1 and FLUSH (stage_rst 2 cycles), settled=0, 8th sample gives no hpf_en; 7 samples of 511 followed by 0 -> no clip.
- stop one cycle after a strobe in RUN -> IDLE, no lpf_en or y_valid for that sample, busy=0; start in the same cycle as stop -> FLUSH.
- rst asserted mid-FLUSH and mid-pipeline -> all outputs 0 next cycle, IDLE, sticky flags cleared.
